// File: rtl/led_arb_ctrl.sv
// led_arb_ctrl -- three-requester LED arbiter.
//
// Grants ownership of the board LEDs to one of three requesters. The owner's
// mode (OFF / ON / BLINK / BREATH) is latched at grant time and drives the
// LEDs until the owner drops its request or is preempted. Preemption is only
// possible after the owner has held the LEDs for HOLD_CYC cycles. Every loss
// of ownership passes through a single-cycle RELEASE state with LEDs dark.
//
// Build option: define LED_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (first pending requester after the last owner) with "any other request"
// preemption instead of fixed priority (bit 0 highest).
//
// Ports:
//   sys_clk       in   system clock, the only clock
//   rst           in   synchronous active-high reset
//   req[2:0]      in   request lines, bit 0 highest priority
//   req_mode[5:0] in   mode per requester, [2i+1:2i] for requester i
//   breath_led    in   LED pattern from the external breathing-LED block
//   breath_valid  out  enable to the breathing block (low restarts its cycle)
//   grant[2:0]    out  one-hot current owner, zero when no owner
//   led[3:0]      out  board LED drive
//   busy          out  high while in OWN or RELEASE
module led_arb_ctrl #(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [5:0] req_mode,
    input  logic [3:0] breath_led,
    output logic       breath_valid,
    output logic [2:0] grant,
    output logic [3:0] led,
    output logic       busy
);

    localparam int HW = 25;
    localparam int BW = 24;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_ON     = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_BREATH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [2:0]      grant_reg;
    logic [3:0]      led_reg;
    logic            breath_valid_reg;
    logic            busy_reg;
    logic [1:0]      cur_mode_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [BW-1:0]   blink_cnt_reg;
    logic            blink_on_reg;

    // Per-requester mode fields.
    logic [1:0] mode_arr [3];
    // Fixed-priority winner as one-hot.
    logic [2:0] win_fixed;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_req
            localparam logic [2:0] LOWER_MASK = 3'((1 << gi) - 1);
            assign mode_arr[gi]  = req_mode[2*gi +: 2];
            assign win_fixed[gi] = req[gi] & ~(|(req & LOWER_MASK));
        end
    endgenerate

    logic [2:0] win_oh;
    logic [1:0] win_mode;

`ifdef LED_ARB_ROUND_ROBIN_EN
    logic [1:0] last_owner_reg;
    logic [1:0] last_owner_next;

    // Search cyclically starting just after the last owner.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        win_oh          = 3'b000;
        last_owner_next = last_owner_reg;
        found           = 1'b0;
        cand            = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last_owner_reg) + k) % 3);
            if (!found && req[cand]) begin
                win_oh          = 3'b001 << cand;
                last_owner_next = cand;
                found           = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_oh = win_fixed;
    end
`endif

    always_comb begin
        win_mode = MODE_OFF;
        for (int k = 0; k < 3; k++) begin
            win_mode = win_mode | ({2{win_oh[k]}} & mode_arr[k]);
        end
    end

    // Ownership checks, derived from the one-hot grant: grant-1 yields the
    // mask of all higher-priority (lower-index) requesters.
    logic owner_req;
    logic higher_req;
    logic other_req;
    logic hold_expired;
    logic release_now;

    assign owner_req    = |(req & grant_reg);
    assign higher_req   = |(req & (grant_reg - 3'd1));
    assign other_req    = |(req & ~grant_reg);
    assign hold_expired = (hold_cnt_reg == HW'(HOLD_CYC));

`ifdef LED_ARB_ROUND_ROBIN_EN
    assign release_now = !owner_req || (other_req && hold_expired);
`else
    assign release_now = !owner_req || (higher_req && hold_expired);
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            grant_reg        <= 3'b000;
            led_reg          <= 4'b0000;
            breath_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            cur_mode_reg     <= MODE_OFF;
            hold_cnt_reg     <= '0;
            blink_cnt_reg    <= '0;
            blink_on_reg     <= 1'b1;
`ifdef LED_ARB_ROUND_ROBIN_EN
            last_owner_reg   <= 2'd2;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    led_reg          <= 4'b0000;
                    breath_valid_reg <= 1'b0;
                    grant_reg        <= 3'b000;
                    busy_reg         <= 1'b0;
                    if (|req) begin
                        state_reg        <= ST_OWN;
                        grant_reg        <= win_oh;
                        cur_mode_reg     <= win_mode;
                        hold_cnt_reg     <= '0;
                        blink_cnt_reg    <= '0;
                        blink_on_reg     <= 1'b1;
                        // The breathing block starts together with the grant.
                        breath_valid_reg <= (win_mode == MODE_BREATH);
                        busy_reg         <= 1'b1;
`ifdef LED_ARB_ROUND_ROBIN_EN
                        last_owner_reg   <= last_owner_next;
`endif
                    end
                end
                ST_OWN: begin
                    if (release_now) begin
                        state_reg        <= ST_RELEASE;
                        grant_reg        <= 3'b000;
                        led_reg          <= 4'b0000;
                        breath_valid_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                    end else begin
                        if (!hold_expired) begin
                            hold_cnt_reg <= hold_cnt_reg + HW'(1);
                        end
                        if (blink_cnt_reg == BW'(BLINK_HALF - 1)) begin
                            blink_cnt_reg <= '0;
                            blink_on_reg  <= ~blink_on_reg;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + BW'(1);
                        end
                        case (cur_mode_reg)
                            MODE_OFF:    led_reg <= 4'b0000;
                            MODE_ON:     led_reg <= 4'b1111;
                            MODE_BLINK:  led_reg <= {4{blink_on_reg}};
                            default:     led_reg <= breath_led;
                        endcase
                    end
                end
                ST_RELEASE: begin
                    state_reg        <= ST_IDLE;
                    grant_reg        <= 3'b000;
                    led_reg          <= 4'b0000;
                    breath_valid_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                end
                default: begin
                    state_reg        <= ST_IDLE;
                    grant_reg        <= 3'b000;
                    led_reg          <= 4'b0000;
                    breath_valid_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    assign grant        = grant_reg;
    assign led          = led_reg;
    assign breath_valid = breath_valid_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_led_arb_ctrl.sv
// Testbench for led_arb_ctrl (HOLD_CYC=8, BLINK_HALF=4). Stimulus is driven
// on the falling edge; a reference model predicts the outputs after the next
// rising edge and queues them, and an independent monitor pops and compares.
module tb_led_arb_ctrl;

    localparam int HOLD = 8;
    localparam int BH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [5:0] req_mode = 6'b0;
    logic [3:0] breath_led = 4'b0;
    logic       breath_valid;
    logic [2:0] grant;
    logic [3:0] led;
    logic       busy;

    always #5 clk = ~clk;

    led_arb_ctrl #(.HOLD_CYC(HOLD), .BLINK_HALF(BH)) dut (
        .sys_clk     (clk),
        .rst         (rst),
        .req         (req),
        .req_mode    (req_mode),
        .breath_led  (breath_led),
        .breath_valid(breath_valid),
        .grant       (grant),
        .led         (led),
        .busy        (busy)
    );

    typedef struct packed {
        logic [2:0] g;
        logic [3:0] l;
        logic       bv;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: who owns the LEDs, since how long, and whether we are
    // in the dark gap right after losing an owner.
    int m_owner = -1;   // -1 = nobody
    bit m_gap   = 1'b0; // in the single release cycle
    int m_mode  = 0;
    int m_age   = 0;    // cycles of ownership elapsed since the grant edge
    int m_last  = 2;

    task automatic step_model(input bit r, input logic [2:0] rq,
                              input logic [5:0] md, input logic [3:0] bl,
                              output exp_t e);
        e = '0;
        if (r) begin
            m_owner = -1; m_gap = 1'b0; m_age = 0; m_last = 2;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            if (rq != 3'b000) begin
`ifdef LED_ARB_ROUND_ROBIN_EN
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last + k) % 3;
                    if (m_owner < 0 && rq[c]) m_owner = c;
                end
                m_last = m_owner;
`else
                if (rq[0]) m_owner = 0;
                else if (rq[1]) m_owner = 1;
                else m_owner = 2;
`endif
                m_mode = (int'(md) >> (2 * m_owner)) & 3;
                m_age  = 0;
                e.g  = 3'(1 << m_owner);
                e.bv = (m_mode == 3);
                e.b  = 1'b1;
            end
        end else begin
            bit expired, contender, drop;
            expired = (m_age >= HOLD);
            drop    = !rq[m_owner];
`ifdef LED_ARB_ROUND_ROBIN_EN
            contender = (int'(rq) & ~(1 << m_owner)) != 0;
`else
            contender = (int'(rq) & ((1 << m_owner) - 1)) != 0;
`endif
            if (drop || (contender && expired)) begin
                m_owner = -1;
                m_gap   = 1'b1;
                e.b     = 1'b1;
            end else begin
                e.g  = 3'(1 << m_owner);
                e.bv = (m_mode == 3);
                e.b  = 1'b1;
                case (m_mode)
                    0: e.l = 4'b0000;
                    1: e.l = 4'b1111;
                    2: e.l = (((m_age / BH) % 2) == 0) ? 4'b1111 : 4'b0000;
                    default: e.l = bl;
                endcase
                m_age++;
            end
        end
    endtask

    task automatic cycle(input bit r, input logic [2:0] rq,
                         input logic [5:0] md, input logic [3:0] bl);
        exp_t e;
        @(negedge clk);
        rst = r; req = rq; req_mode = md; breath_led = bl;
        step_model(r, rq, md, bl, e);
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: one expected response per clock edge.
    logic [2:0] prev_grant = 3'b000;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("grant", int'(grant), int'(e.g));
                check("led", int'(led), int'(e.l));
                check("breath_valid", int'(breath_valid), int'(e.bv));
                check("busy", int'(busy), int'(e.b));
                if (grant != prev_grant && grant != 3'b000)
                    $display("[TB] t=%0t grant=%b led=%b breath_valid=%b", $time, grant, led, breath_valid);
                prev_grant = grant;
            end
        end
    end

    initial begin
        int hold_left;
        logic [2:0] rq;
        logic [5:0] md;
        logic [3:0] bl;

        repeat (3) cycle(1, 3'b000, 6'b0, 4'h0);

        // Requester 1 ON, then drop.
        repeat (12) cycle(0, 3'b010, 6'b00_01_00, 4'h0);
        repeat (3)  cycle(0, 3'b000, 6'b0, 4'h0);

        // Requester 2 BLINK, then drop.
        repeat (20) cycle(0, 3'b100, 6'b10_00_00, 4'h0);
        repeat (3)  cycle(0, 3'b000, 6'b0, 4'h0);

        // Requester 1 ON, higher-priority request arrives early.
        repeat (3)  cycle(0, 3'b010, 6'b00_01_01, 4'h0);
        repeat (16) cycle(0, 3'b011, 6'b00_01_01, 4'h0);
        repeat (3)  cycle(0, 3'b000, 6'b0, 4'h0);

        // Requester 2 BREATH, then preempted by requester 0.
        repeat (6)  cycle(0, 3'b100, 6'b11_00_10, 4'($urandom_range(0, 15)));
        repeat (14) cycle(0, 3'b101, 6'b11_00_10, 4'($urandom_range(0, 15)));
        repeat (3)  cycle(0, 3'b000, 6'b0, 4'h0);

        // Reset while owning.
        repeat (5)  cycle(0, 3'b001, 6'b00_00_01, 4'h0);
        cycle(1, 3'b001, 6'b00_00_01, 4'h0);
        repeat (3)  cycle(0, 3'b000, 6'b0, 4'h0);

        // Randomized traffic.
        hold_left = 0;
        rq = 3'b000;
        md = 6'b0;
        for (int i = 0; i < 2500; i++) begin
            if (hold_left == 0) begin
                rq = 3'($urandom_range(0, 7));
                md = 6'($urandom_range(0, 63));
                hold_left = $urandom_range(1, 30);
            end
            hold_left--;
            bl = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 299) == 0), rq, md, bl);
        end

        repeat (3) cycle(0, 3'b000, 6'b0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("queue_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
